// File: rtl/arbiter_requester_bank_if.sv
// Request/grant bundle between the requester bank and the fixed-priority arbiter.
// The bank side uses master; the arbiter/environment side uses slave.
interface arbiter_requester_bank_if #(
   parameter int unsigned AGENTS = 8,
   parameter int unsigned LEN_W  = 4
);
   logic [AGENTS-1:0]       start;
   logic [AGENTS*LEN_W-1:0] len;
   logic [AGENTS-1:0]       r;
   logic [AGENTS-1:0]       g;
   logic [AGENTS-1:0]       busy;
   logic [AGENTS-1:0]       beat;
   logic [AGENTS-1:0]       done;
   logic                    err;

   modport master (
      input  start, len, g,
      output r, busy, beat, done, err
   );

   modport slave (
      output start, len, g,
      input  r, busy, beat, done, err
   );
endinterface

// File: rtl/arbiter_requester_bank.sv
// Bank of independent burst-request FSMs driving a fixed-priority arbiter,
// with a sticky checker for illegal grant patterns.
module arbiter_requester_bank #(
   parameter int unsigned AGENTS = 8,
   parameter int unsigned LEN_W  = 4
) (
   input logic                    clock,
   input logic                    reset,
   arbiter_requester_bank_if.master bus
);

   typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

   state_e            state_q     [AGENTS];
   logic [LEN_W-1:0]  remaining_q [AGENTS];
   logic [AGENTS-1:0] req_q;
   logic [AGENTS-1:0] r_prev_q;
   logic              err_q;

   logic [AGENTS-1:0] busy;
   logic [AGENTS-1:0] beat;
   logic [AGENTS-1:0] done;
   logic              viol;

   // Grant is one-hot-or-zero and only to agents that requested last cycle.
   always_comb begin
      viol = 1'b0;
      if ((bus.g & (bus.g - AGENTS'(1))) != '0) viol = 1'b1;
      if ((bus.g & ~r_prev_q) != '0) viol = 1'b1;
   end

   always_comb begin
      busy = '0;
      beat = '0;
      done = '0;
      for (int i = 0; i < AGENTS; i++) begin
         busy[i] = (state_q[i] != StIdle);
         beat[i] = (state_q[i] == StActive) && bus.g[i];
         done[i] = (state_q[i] == StActive) && bus.g[i] && (remaining_q[i] == LEN_W'(1));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < AGENTS; i++) begin
            state_q[i]     <= StIdle;
            remaining_q[i] <= '0;
         end
         req_q    <= '0;
         r_prev_q <= '0;
         err_q    <= 1'b0;
      end else begin
         r_prev_q <= req_q;
         err_q    <= err_q | viol;
         for (int i = 0; i < AGENTS; i++) begin
            unique case (state_q[i])
               StIdle: begin
                  if (bus.start[i] && (bus.len[i*LEN_W +: LEN_W] != '0)) begin
                     state_q[i]     <= StActive;
                     remaining_q[i] <= bus.len[i*LEN_W +: LEN_W];
                     req_q[i]       <= 1'b1;
                  end
               end
               StActive: begin
                  if (bus.g[i]) begin
                     remaining_q[i] <= remaining_q[i] - LEN_W'(1);
                     if (remaining_q[i] == LEN_W'(1)) begin
                        state_q[i] <= StDrain;
                        req_q[i]   <= 1'b0;
                     end
                  end
               end
               // Late grant from the arbiter's registered lag is ignored here.
               StDrain: state_q[i] <= StIdle;
               default: begin
                  state_q[i] <= StIdle;
                  req_q[i]   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.r    = req_q;
   assign bus.busy = busy;
   assign bus.beat = beat;
   assign bus.done = done;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_arbiter_requester_bank.sv
// Directed bench for arbiter_requester_bank against a registered fixed-priority
// arbiter stand-in, with a per-cycle behavioural model and literal expectations.
module tb_arbiter_requester_bank;
   localparam int unsigned AGENTS = 8;
   localparam int unsigned LEN_W  = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   arbiter_requester_bank_if #(.AGENTS(AGENTS), .LEN_W(LEN_W)) bus ();

   arbiter_requester_bank #(.AGENTS(AGENTS), .LEN_W(LEN_W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Arbiter stand-in: registers r, grants the lowest set index; force overrides it.
   logic [AGENTS-1:0] arb_q;
   logic              force_en;
   logic [AGENTS-1:0] force_g;

   function automatic logic [AGENTS-1:0] prio(input logic [AGENTS-1:0] v);
      logic [AGENTS-1:0] o;
      o = '0;
      for (int k = AGENTS - 1; k >= 0; k--) if (v[k]) o = AGENTS'(1) << k;
      return o;
   endfunction

   always @(posedge clock) begin
      if (reset) arb_q <= '0;
      else       arb_q <= prio(bus.r);
   end
   assign bus.g = force_en ? force_g : arb_q;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit model_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int lenof(input int k);
      return int'(bus.len[k*LEN_W +: LEN_W]);
   endfunction

   // Model: beats still owed per agent, plus a one-cycle cool-down after the last beat.
   int                left [AGENTS];
   bit                drn  [AGENTS];
   bit                m_err;
   logic [AGENTS-1:0] m_rprev;
   logic [AGENTS-1:0] er, eb, ebeat, edone;

   initial begin
      for (int k = 0; k < AGENTS; k++) begin
         left[k] = 0;
         drn[k]  = 1'b0;
      end
      m_err   = 1'b0;
      m_rprev = '0;
   end

   always @(negedge clock) begin
      if (model_on) begin
         for (int k = 0; k < AGENTS; k++) begin
            er[k]    = left[k] > 0;
            eb[k]    = (left[k] > 0) || drn[k];
            ebeat[k] = (left[k] > 0) && bus.g[k];
            edone[k] = (left[k] == 1) && bus.g[k];
         end
         chk("m_r", 32'(bus.r), 32'(er));
         chk("m_busy", 32'(bus.busy), 32'(eb));
         chk("m_beat", 32'(bus.beat), 32'(ebeat));
         chk("m_done", 32'(bus.done), 32'(edone));
         chk("m_err", 32'(bus.err), 32'(m_err));
         if (reset) begin
            for (int k = 0; k < AGENTS; k++) begin
               left[k] = 0;
               drn[k]  = 1'b0;
            end
            m_err   = 1'b0;
            m_rprev = '0;
         end else begin
            if (($countones(bus.g) > 1) || ((bus.g & ~m_rprev) != '0)) m_err = 1'b1;
            m_rprev = er;
            for (int k = 0; k < AGENTS; k++) begin
               if (drn[k]) drn[k] = 1'b0;
               else if (left[k] > 0) begin
                  if (bus.g[k]) begin
                     left[k]--;
                     if (left[k] == 0) drn[k] = 1'b1;
                  end
               end else if (bus.start[k] && lenof(k) != 0) left[k] = lenof(k);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic set_len(input int a, input int v);
      bus.len[a*LEN_W +: LEN_W] = LEN_W'(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.start = '0;
      bus.len = '0;
      force_en = 1'b0;
      force_g = '0;
      step();
      step();
      model_on = 1'b1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_r", 32'(bus.r), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_err", 32'(bus.err), 0);

      // Single burst: agent 3, len 3.
      for (int c = 0; c < 8; c++) begin
         step();
         bus.start = (c == 0) ? 8'h08 : 8'h00;
         if (c == 0) set_len(3, 3);
         @(negedge clock);
         chk("s_r3", 32'(bus.r[3]), 32'(c >= 1 && c <= 4));
         chk("s_beat3", 32'(bus.beat[3]), 32'(c >= 2 && c <= 4));
         chk("s_done3", 32'(bus.done[3]), 32'(c == 4));
         chk("s_busy3", 32'(bus.busy[3]), 32'(c >= 1 && c <= 5));
         chk("s_err", 32'(bus.err), 0);
      end

      // Preemption: agent 5 len 4 at cycle 0, agent 1 len 2 at cycle 2.
      for (int c = 0; c < 11; c++) begin
         step();
         bus.start = (c == 0) ? 8'h20 : (c == 2) ? 8'h02 : 8'h00;
         if (c == 0) set_len(5, 4);
         if (c == 2) set_len(1, 2);
         @(negedge clock);
         chk("p_beat5", 32'(bus.beat[5]), 32'(c == 2 || c == 3 || c == 7 || c == 8));
         chk("p_beat1", 32'(bus.beat[1]), 32'(c == 4 || c == 5));
         chk("p_done1", 32'(bus.done[1]), 32'(c == 5));
         chk("p_done5", 32'(bus.done[5]), 32'(c == 8));
         if (c == 6) begin
            chk("p_g1_late", 32'(bus.g[1]), 1);
            chk("p_busy1_drain", 32'(bus.busy[1]), 1);
         end
         chk("p_err", 32'(bus.err), 0);
      end

      // All agents, len 1 each.
      for (int c = 0; c < 19; c++) begin
         step();
         bus.start = (c == 0) ? 8'hFF : 8'h00;
         if (c == 0) for (int k = 0; k < AGENTS; k++) set_len(k, 1);
         @(negedge clock);
         chk("a_onebeat", 32'($countones(bus.beat) <= 1), 1);
         for (int k = 0; k < AGENTS; k++) chk("a_done", 32'(bus.done[k]), 32'(c == 2 + 2 * k));
         chk("a_err", 32'(bus.err), 0);
      end

      // Ignored starts: agent 4 len 0; agent 2 re-started mid-burst.
      for (int c = 0; c < 8; c++) begin
         step();
         bus.start = (c == 0) ? 8'h14 : (c == 3) ? 8'h04 : 8'h00;
         if (c == 0) begin
            bus.len = '0;
            set_len(2, 3);
         end
         if (c == 3) set_len(2, 5);
         @(negedge clock);
         chk("i_r4", 32'(bus.r[4]), 0);
         chk("i_busy4", 32'(bus.busy[4]), 0);
         chk("i_beat2", 32'(bus.beat[2]), 32'(c >= 2 && c <= 4));
         chk("i_done2", 32'(bus.done[2]), 32'(c == 4));
         chk("i_busy2", 32'(bus.busy[2]), 32'(c >= 1 && c <= 5));
      end

      // Protocol checker: two grant bits at once.
      for (int c = 0; c < 5; c++) begin
         step();
         force_en = (c == 0);
         force_g = 8'h03;
         @(negedge clock);
         chk("c_err_multi", 32'(bus.err), 32'(c >= 1));
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      // Protocol checker: grant to an agent that never requested.
      for (int c = 0; c < 4; c++) begin
         step();
         force_en = (c == 0);
         force_g = 8'h40;
         @(negedge clock);
         chk("c_err_orphan", 32'(bus.err), 32'(c >= 1));
      end

      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      // Reset mid-burst, then a fresh burst from cycle 5.
      for (int c = 0; c < 12; c++) begin
         step();
         bus.start = (c == 0 || c == 5) ? 8'h08 : 8'h00;
         if (c == 0) set_len(3, 3);
         reset = (c == 3);
         @(negedge clock);
         if (c == 4) begin
            chk("x_r", 32'(bus.r), 0);
            chk("x_busy", 32'(bus.busy), 0);
            chk("x_err", 32'(bus.err), 0);
         end
         chk("x_beat3", 32'(bus.beat[3]), 32'((c >= 2 && c <= 3) || (c >= 7 && c <= 9)));
         chk("x_done3", 32'(bus.done[3]), 32'(c == 9));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/arbiter_requester_bank.md
# arbiter_requester_bank

Requester-side companion to the fixed-priority `Arbiter`. It holds `AGENTS` independent request FSMs. Each FSM accepts a burst job of N beats, raises its request line, and counts granted cycles as beats. After the last beat it releases the line and drains the arbiter's one-cycle grant lag. The block drives the arbiter's `r` vector, consumes its `g` vector, and checks the grant stream for protocol violations.

## Interface
- `AGENTS`, default 8: number of requesters; must match the arbiter. Index 0 has the highest priority.
- `LEN_W`, default 4: width of the per-agent burst-length field; legal burst length is 1..2^LEN_W-1.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  AGENTS  per-agent job strobe; sampled only while that agent is IDLE.
- `len`  in  AGENTS*LEN_W  per-agent burst length; agent i uses bits [i*LEN_W +: LEN_W].
- `r`  out  AGENTS  request vector to the arbiter; registered.
- `g`  in  AGENTS  grant vector from the arbiter.
- `busy`  out  AGENTS  agent i is not IDLE; derived from registered state.
- `beat`  out  AGENTS  agent i consumed a granted beat this cycle; combinational.
- `done`  out  AGENTS  one-cycle pulse coincident with agent i's final beat; combinational.
- `err`  out  1  sticky protocol-violation flag; registered.

## Operation
- Each agent i has one FSM with states IDLE, ACTIVE and DRAIN, plus a LEN_W-bit `remaining` counter.
- **IDLE:**
  - `r[i]`=0.
  - If `start[i]` is high and `len[i]` is nonzero, load `remaining` with `len[i]` and go to ACTIVE.
  - A start with `len[i]`=0 is ignored: no state change, no `done`.
- **ACTIVE:**
  - `r[i]`=1.
  - In any cycle with `g[i]`=1, `beat[i]`=1 and `remaining` decrements.
  - If `remaining`==1 and `g[i]`=1, `done[i]`=1 and the FSM goes to DRAIN.
  - A cycle with `g[i]`=0 (not yet granted, or preempted by a lower index) stalls with no count change.
- **DRAIN:**
  - Lasts exactly one cycle, then the FSM returns to IDLE.
  - `r[i]`=0, and `g[i]` is ignored. The arbiter registers requests, so its grant lags by one cycle and may still be high here.
- `start[i]` is ignored in ACTIVE and DRAIN; no job queueing.
- `r` is registered: `r[i]` is 1 exactly when the registered state is ACTIVE.
- `beat[i]` = (state==ACTIVE) & `g[i]`.
- `done[i]` = `beat[i]` & (`remaining`==1).
- **Protocol checker:** the block keeps `r_q`, the value of `r` from the previous cycle. A cycle violates the protocol when either condition holds:
  - `g` has more than one bit set, or
  - `g` has any bit set where `r_q` is 0.
- A violation sets `err` at the next edge. `err` stays high until reset and does not affect the FSMs.
- **Reset:** overrides everything, including mid-burst.
  - All FSMs go to IDLE; `remaining`=0, `r`=0, `r_q`=0, `err`=0.
  - Consequently `busy`, `beat` and `done` are 0.
  - No `done` is issued for an aborted burst.

## Timing
- `start` is sampled in cycle 0. `r[i]` and `busy[i]` are high from cycle 1. The earliest grant is in cycle 2, because the arbiter samples `r` at the end of cycle 1.
- Uncontested burst of length L:
  - Beats in cycles 2..L+1; `done` in cycle L+1.
  - DRAIN in cycle L+2; IDLE in cycle L+3.
  - The next start is accepted in cycle L+3.
- After any agent drops `r`, a lower-priority agent sees its grant at the earliest 2 cycles after the releasing agent's final beat.
- `beat` and `done` are combinational from `g`. Consumers must register them; the block adds no extra latency.
- Boundary cases:
  - `remaining` never underflows: `done` and the state change occur on the same edge.
  - A start on the same edge as the return from DRAIN to IDLE is not accepted; start is sampled only while the state is already IDLE.

## Test plan
- **Single burst:** agent 3, `len`=3, start in cycle 0, connected to `Arbiter`. Required: `r[3]` high cycles 1-4; `beat[3]` in cycles 2, 3, 4; `done[3]` in cycle 4; `busy[3]` low from cycle 6; `err`=0.
- **Preemption:** agent 5 `len`=4 starts in cycle 0; agent 1 `len`=2 starts in cycle 2. Required:
  - `beat[5]` in cycles 2, 3, 7, 8.
  - `beat[1]` in cycles 4, 5.
  - `done[1]` in cycle 5, `done[5]` in cycle 8.
  - `g[1]` high in cycle 6 is ignored by the DRAIN state.
- **All agents:** `start`=8'hFF with every `len`=1 in cycle 0. Required: agent k's `done` occurs in cycle 2+2k, so agent 7 completes in cycle 16; at most one `beat` bit is set per cycle.
- **Ignored starts:** a start with `len`=0 produces no `r` and no `busy`. A start pulsed on agent 2 mid-burst does not alter `remaining` or extend the burst.
- **Protocol checker:** force `g`=8'b0000_0011 for one cycle → `err`=1 the next cycle and held. Then reset and force `g[6]`=1 with `r_q[6]`=0 → `err`=1 the next cycle.
- **Reset mid-burst:** run the single-burst scenario and assert `reset` in cycle 3. Required: in cycle 4, `r`=0, `busy`=0 and `err`=0, with no `done`. A new start in cycle 5 completes normally.
